// File: rtl/reindeer_mem_arbiter.sv
// Single-port memory arbiter: fixed priority ocd > code > data, read-tag return pipeline,
// wait states and a code/data starvation guard. Define REINDEER_MEM_ARB_RDATA_REG_EN to register rdata/rvalids.

module reindeer_mem_arbiter #(
   parameter int XLEN         = 32,
   parameter int ADDR_BITS    = 14,
   parameter int READ_LATENCY = 1,
   parameter int WAIT_STATES  = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 sync_reset,
   input  logic                 ocd_req,
   input  logic                 ocd_we,
   input  logic [ADDR_BITS-1:0] ocd_addr,
   input  logic [XLEN-1:0]      ocd_wdata,
   output logic                 ocd_gnt,
   output logic                 ocd_rvalid,
   input  logic                 code_req,
   input  logic [ADDR_BITS-1:0] code_addr,
   output logic                 code_gnt,
   output logic                 code_rvalid,
   input  logic                 data_req,
   input  logic [XLEN/8-1:0]    data_be,
   input  logic [ADDR_BITS-1:0] data_addr,
   input  logic [XLEN-1:0]      data_wdata,
   output logic                 data_gnt,
   output logic                 data_rvalid,
   output logic [XLEN-1:0]      rdata,
   output logic                 busy,
   output logic                 mem_en,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [XLEN/8-1:0]    mem_write_en,
   output logic [XLEN-1:0]      mem_write_data,
   input  logic [XLEN-1:0]      mem_read_data
);

   localparam int         NBE          = XLEN / 8;
   localparam logic [2:0] STARVE_LIMIT = 3'd4;

   typedef enum logic [1:0] {TAG_NONE, TAG_OCD, TAG_CODE, TAG_DATA} tag_e;

   tag_e       tag_q [READ_LATENCY];
   tag_e       tag_d [READ_LATENCY];
   logic [2:0] wait_q, wait_d;
   logic [2:0] starve_q, starve_d;
   tag_e       winner;
   logic       win_read;
   tag_e       tag_out;
   tag_e       rvalid_tag;

   // Once code has won STARVE_LIMIT times in a row against a waiting data port, data jumps ahead of code.
   always_comb begin
      winner = TAG_NONE;
      if (reset_n && !sync_reset && (wait_q == 3'd0)) begin
         if (ocd_req)                                    winner = TAG_OCD;
         else if (data_req && (starve_q == STARVE_LIMIT)) winner = TAG_DATA;
         else if (code_req)                               winner = TAG_CODE;
         else if (data_req)                               winner = TAG_DATA;
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first, so no path through the case infers a latch.
      mem_en         = (winner != TAG_NONE);
      mem_addr       = '0;
      mem_write_en   = '0;
      mem_write_data = '0;
      win_read       = 1'b0;
      case (winner)
         TAG_OCD: begin
            mem_addr       = ocd_addr;
            mem_write_data = ocd_wdata;
            mem_write_en   = {NBE{ocd_we}};
            win_read       = !ocd_we;
         end
         TAG_CODE: begin
            mem_addr = code_addr;
            win_read = 1'b1;
         end
         TAG_DATA: begin
            mem_addr       = data_addr;
            mem_write_data = data_wdata;
            mem_write_en   = data_be;
            win_read       = (data_be == '0);
         end
         default: ;
      endcase
   end

   assign ocd_gnt  = (winner == TAG_OCD);
   assign code_gnt = (winner == TAG_CODE);
   assign data_gnt = (winner == TAG_DATA);
   assign busy     = (wait_q != 3'd0);

   always_comb begin
      tag_d[0] = win_read ? winner : TAG_NONE;
      for (int i = 1; i < READ_LATENCY; i++) begin
         tag_d[i] = tag_q[i-1];
      end

      wait_d = wait_q;
      if (winner != TAG_NONE)  wait_d = 3'(WAIT_STATES);
      else if (wait_q != 3'd0) wait_d = wait_q - 3'd1;

      starve_d = starve_q;
      if (!data_req || (winner == TAG_DATA))                     starve_d = 3'd0;
      else if ((winner == TAG_CODE) && (starve_q < STARVE_LIMIT)) starve_d = starve_q + 3'd1;

      if (sync_reset) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            tag_d[i] = TAG_NONE;
         end
         wait_d   = 3'd0;
         starve_d = 3'd0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            tag_q[i] <= TAG_NONE;
         end
         wait_q   <= 3'd0;
         starve_q <= 3'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         tag_q    <= tag_d;
         wait_q   <= wait_d;
         starve_q <= starve_d;
      end
   end

   assign tag_out = tag_q[READ_LATENCY-1];

`ifdef REINDEER_MEM_ARB_RDATA_REG_EN
   tag_e            rtag_q, rtag_d;
   logic [XLEN-1:0] rdata_q, rdata_d;

   always_comb begin
      rtag_d  = sync_reset ? TAG_NONE : tag_out;
      rdata_d = mem_read_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rtag_q  <= TAG_NONE;
         rdata_q <= '0;
      end else begin
         rtag_q  <= rtag_d;
         rdata_q <= rdata_d;
      end
   end

   assign rvalid_tag = sync_reset ? TAG_NONE : rtag_q;
   assign rdata      = rdata_q;
`else
   assign rvalid_tag = sync_reset ? TAG_NONE : tag_out;
   assign rdata      = mem_read_data;
`endif

   assign ocd_rvalid  = (rvalid_tag == TAG_OCD);
   assign code_rvalid = (rvalid_tag == TAG_CODE);
   assign data_rvalid = (rvalid_tag == TAG_DATA);

endmodule

// File: doc/reindeer_mem_arbiter.md
REINDEER_MEM_ARBITER -- requirements
Module: reindeer_mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_BITS, default 14, word address width.
REQ-003 Parameter READ_LATENCY, default 1, range 1..4, memory cycles from access to valid mem_read_data.
REQ-004 Parameter WAIT_STATES, default 0, range 0..7, extra busy cycles inserted after every access.
REQ-005 Ports: clk in 1, sole clock; reset_n in 1, asynchronous active-low reset; sync_reset in 1, synchronous clear.
REQ-006 Ports: ocd_req in 1; ocd_we in 1; ocd_addr in ADDR_BITS; ocd_wdata in XLEN; ocd_gnt out 1; ocd_rvalid out 1.
REQ-007 Ports: code_req in 1; code_addr in ADDR_BITS; code_gnt out 1; code_rvalid out 1.
REQ-008 Ports: data_req in 1; data_be in XLEN/8, byte write enables (all zero = read); data_addr in ADDR_BITS; data_wdata in XLEN; data_gnt out 1; data_rvalid out 1.
REQ-009 Ports: rdata out XLEN, shared read return; busy out 1, high while wait states run.
REQ-010 Ports: mem_en out 1; mem_addr out ADDR_BITS; mem_write_en out XLEN/8; mem_write_data out XLEN; mem_read_data in XLEN.

Function
REQ-011 Arbitration SHALL be combinational in the request cycle; grant is asserted in the same cycle as the accepted request.
REQ-012 Fixed priority SHALL be ocd > code > data, except as modified by REQ-019.
REQ-013 At most one grant SHALL be high per cycle; no grant SHALL be issued while busy=1.
REQ-014 On a grant, mem_en=1 and mem_addr/mem_write_data SHALL come from the winner; ocd write drives all byte enables, data drives data_be, reads drive zero.
REQ-015 With no grant, mem_en=0 and mem_write_en=0.
REQ-016 Each granted read SHALL push a port tag into a READ_LATENCY-deep shift pipeline; the matching *_rvalid SHALL pulse exactly READ_LATENCY cycles after the grant, with rdata=mem_read_data.
REQ-017 Writes SHALL produce no rvalid; back-to-back reads with WAIT_STATES=0 SHALL yield one rvalid per cycle in grant order.
REQ-018 After any grant, a wait counter SHALL load WAIT_STATES; busy=1 while counter non-zero; counter decrements by 1 per cycle.
REQ-019 Starvation counter: counts consecutive code grants while data_req=1; on reaching 4, the next arbitration SHALL favour data over code (ocd still first); counter clears on a data grant or when data_req=0.
REQ-020 Requesters SHALL hold req and payload until grant; a dropped request is not served.
REQ-021 rdata SHALL equal mem_read_data when no rvalid is high (no extra muxing required).

Reset
REQ-022 reset_n low SHALL asynchronously clear tag pipeline, wait counter, starvation counter; all grants, rvalids, busy, mem_en, mem_write_en = 0.
REQ-023 sync_reset high SHALL clear the same state at the next clk edge and suppress grants in that cycle; in-flight reads SHALL be discarded (no rvalid).

Configuration
REQ-024 Macro REINDEER_MEM_ARB_RDATA_REG_EN defined: rdata and all *_rvalid SHALL be registered, adding one cycle (rvalid at READ_LATENCY+1); undefined: behaviour per REQ-016.

Verification
REQ-025 ocd_req, code_req, data_req all high same cycle, WAIT_STATES=0 -> ocd_gnt cycle 0, code_gnt cycle 1, data_gnt cycle 2.
REQ-026 code read at addr 0x10 returning 0xDEADBEEF, READ_LATENCY=3 -> code_rvalid exactly 3 cycles after code_gnt with rdata=0xDEADBEEF, no other rvalid.
REQ-027 data write be=4'b0011 addr 0x20 wdata 0x12345678 -> mem_write_en=4'b0011, mem_addr=0x20, no data_rvalid.
REQ-028 WAIT_STATES=2, two pending code reads -> grants 3 cycles apart, busy high 2 cycles between.
REQ-029 code_req and data_req held high continuously -> data_gnt after 4 code grants, then counter restarts.
REQ-030 reset_n pulsed low with 2 reads in flight -> all outputs 0 immediately, no rvalid after release.
